// File: rtl/fbm_sched_pkg.sv
// fbm_sched_pkg: shared scheduler state enum, width helper and stall counter width
package fbm_sched_pkg;
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, REPORT, DONE} state_t;
  localparam int STALL_W = 16;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fbm_frame_sched_if.sv
// fbm_frame_sched_if: scheduler bus; master drives en_init/run/mb_x/mb_y/mb_done_valid/busy/frame_done/stall_cycles, slave drives frame_start/frame_abort/mb_done_ready
interface fbm_frame_sched_if #(parameter int XW = 1, parameter int YW = 1);
  logic frame_start;
  logic frame_abort;
  logic en_init;
  logic run;
  logic [XW-1:0] mb_x;
  logic [YW-1:0] mb_y;
  logic mb_done_valid;
  logic mb_done_ready;
  logic busy;
  logic frame_done;
  logic [fbm_sched_pkg::STALL_W-1:0] stall_cycles;
  modport master(
    input frame_start, frame_abort, mb_done_ready,
    output en_init, run, mb_x, mb_y, mb_done_valid, busy, frame_done, stall_cycles
  );
  modport slave(
    output frame_start, frame_abort, mb_done_ready,
    input en_init, run, mb_x, mb_y, mb_done_valid, busy, frame_done, stall_cycles
  );
endinterface

// File: rtl/fbm_wrap_cnt.sv
// fbm_wrap_cnt: counter 0..MAX wrapping to 0; ports clk, rst, clr, inc -> cnt, at_max (clr beats inc)
module fbm_wrap_cnt
  import fbm_sched_pkg::*;
#(
  parameter int MAX = 1,
  localparam int W = clog2_min1(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);
  logic [W-1:0] cnt_q;
  assign at_max = cnt_q == W'(MAX);
  assign cnt = cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || clr) ? '0 : inc ? (at_max ? '0 : cnt_q + 1'b1) : cnt_q;
endmodule

// File: rtl/fbm_frame_sched.sv
// fbm_frame_sched: raster macroblock scheduler (INIT/RUN/DRAIN/REPORT per mb); ports clk, rst, sched (fbm_frame_sched_if.master); FBM_SCHED_PERF_EN enables stall_cycles
module fbm_frame_sched
  import fbm_sched_pkg::*;
#(
  parameter int MB_COLS        = 22,
  parameter int MB_ROWS        = 18,
  parameter int INIT_CYCLES    = 73,
  parameter int PERIOD         = 24,
  parameter int PERIODS_PER_MB = 32,
  parameter int DRAIN_CYCLES   = 3
) (
  input logic clk,
  input logic rst,
  fbm_frame_sched_if.master sched
);
  localparam int LONG    = (INIT_CYCLES > PERIOD) ? INIT_CYCLES : PERIOD;
  localparam int CYC_MAX = ((LONG > DRAIN_CYCLES) ? LONG : DRAIN_CYCLES) - 1;
  localparam int CW      = clog2_min1(CYC_MAX + 1);
  localparam int PW      = clog2_min1(PERIODS_PER_MB);
  localparam int XW      = clog2_min1(MB_COLS);
  localparam int YW      = clog2_min1(MB_ROWS);
  state_t state_q, state_d;
  logic en_init_q, run_q, valid_q, busy_q, done_q;
  logic cyc_clr, cyc_inc, per_clr, per_inc, mb_clr, mb_inc;
  logic [CW-1:0] cyc;
  logic [PW-1:0] per_unused;
  logic [XW-1:0] mb_x;
  logic [YW-1:0] mb_y;
  logic cyc_top_unused, per_last, x_last, y_last;
  fbm_wrap_cnt #(.MAX(CYC_MAX)) u_cyc (
    .clk(clk), .rst(rst), .clr(cyc_clr), .inc(cyc_inc), .cnt(cyc), .at_max(cyc_top_unused)
  );
  fbm_wrap_cnt #(.MAX(PERIODS_PER_MB - 1)) u_per (
    .clk(clk), .rst(rst), .clr(per_clr), .inc(per_inc), .cnt(per_unused), .at_max(per_last)
  );
  fbm_wrap_cnt #(.MAX(MB_COLS - 1)) u_mbx (
    .clk(clk), .rst(rst), .clr(mb_clr), .inc(mb_inc), .cnt(mb_x), .at_max(x_last)
  );
  fbm_wrap_cnt #(.MAX(MB_ROWS - 1)) u_mby (
    .clk(clk), .rst(rst), .clr(mb_clr), .inc(mb_inc && x_last), .cnt(mb_y), .at_max(y_last)
  );
  always_comb begin
    state_d = state_q;
    cyc_clr = 1'b0;
    cyc_inc = 1'b0;
    per_clr = 1'b0;
    per_inc = 1'b0;
    mb_clr  = 1'b0;
    mb_inc  = 1'b0;
    unique case (state_q)
      IDLE: if (sched.frame_start && !sched.frame_abort) begin
        state_d = INIT;
        cyc_clr = 1'b1;
        mb_clr  = 1'b1;
      end
      INIT: begin
        cyc_inc = 1'b1;
        if (cyc == CW'(INIT_CYCLES - 1)) begin
          state_d = RUN;
          cyc_clr = 1'b1;
          per_clr = 1'b1;
        end
      end
      RUN: begin
        cyc_inc = 1'b1;
        if (cyc == CW'(PERIOD - 1)) begin
          cyc_clr = 1'b1;
          per_inc = 1'b1;
          state_d = per_last ? ((DRAIN_CYCLES == 0) ? REPORT : DRAIN) : RUN;
        end
      end
      DRAIN: begin
        cyc_inc = 1'b1;
        if (cyc == CW'(DRAIN_CYCLES - 1)) begin
          state_d = REPORT;
          cyc_clr = 1'b1;
        end
      end
      REPORT: if (sched.mb_done_ready) begin
        state_d = (x_last && y_last) ? DONE : INIT;
        mb_inc  = !(x_last && y_last);
        cyc_clr = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over a same-cycle handshake, so the position must not advance
    if (sched.frame_abort && state_q != IDLE) begin
      state_d = IDLE;
      mb_inc  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state_q   <= rst ? IDLE : state_d;
    en_init_q <= !rst && state_d == INIT;
    run_q     <= !rst && state_d == RUN;
    valid_q   <= !rst && state_d == REPORT;
    busy_q    <= !rst && state_d != IDLE;
    done_q    <= !rst && state_d == DONE;
  end
  assign sched.en_init       = en_init_q;
  assign sched.run           = run_q;
  assign sched.mb_done_valid = valid_q;
  assign sched.busy          = busy_q;
  assign sched.frame_done    = done_q;
  assign sched.mb_x          = mb_x;
  assign sched.mb_y          = mb_y;
`ifdef FBM_SCHED_PERF_EN
  logic [STALL_W-1:0] stall_q;
  always_ff @(posedge clk)
    stall_q <= (rst || (state_q == IDLE && state_d == INIT)) ? '0 :
               (state_q == REPORT && !sched.mb_done_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  assign sched.stall_cycles = stall_q;
`else
  assign sched.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fbm_frame_sched.sv
// tb_fbm_frame_sched: randomized scoreboard bench for fbm_frame_sched (2x2 mbs, 4 init, 24x2 run, 3 drain)
module tb_fbm_frame_sched;
  localparam int MB_COLS = 2, MB_ROWS = 2, INIT_C = 4, PERIOD = 24, PPM = 2, DRAIN_C = 3;
  localparam int MB_CYC = INIT_C + PERIOD * PPM + DRAIN_C + 1;
`ifdef FBM_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {int x; int y; int s;} mb_t;
  typedef struct {int busy; int stall; bit done;} fr_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, failures = 0;
  mb_t mb_q[$];
  fr_t fr_q[$];
  mb_t me;
  fr_t fe;
  int en_n = 0, run_n = 0, dr_n = 0, st_n = 0, busy_n = 0;
  bit fd_exp = 0, fd_seen = 0, pb = 0;
  always #5 clk = ~clk;
  fbm_frame_sched_if #(.XW(1), .YW(1)) bus ();
  fbm_frame_sched #(
    .MB_COLS(MB_COLS), .MB_ROWS(MB_ROWS), .INIT_CYCLES(INIT_C),
    .PERIOD(PERIOD), .PERIODS_PER_MB(PPM), .DRAIN_CYCLES(DRAIN_C)
  ) dut (.clk(clk), .rst(rst), .sched(bus.master));
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int outs();
    return int'({bus.en_init, bus.run, bus.mb_x, bus.mb_y, bus.mb_done_valid, bus.busy,
                 bus.frame_done, bus.stall_cycles});
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus.busy) busy_n++;
    if (bus.en_init) en_n++;
    if (bus.run) run_n++;
    if (bus.busy && !bus.en_init && !bus.run && !bus.mb_done_valid && !bus.frame_done) dr_n++;
    if (bus.frame_done || fd_exp) chk("frame_done", bus.frame_done, fd_exp);
    fd_seen = fd_seen | bus.frame_done;
    fd_exp = 0;
    if (bus.mb_done_valid && !bus.mb_done_ready) begin
      st_n++;
      if (mb_q.size() > 0) begin
        chk("stall_x", bus.mb_x, mb_q[0].x);
        chk("stall_y", bus.mb_y, mb_q[0].y);
      end
    end
    if (bus.mb_done_valid && bus.mb_done_ready && !bus.frame_abort && !rst) begin
      if (mb_q.size() == 0) chk("mb_unexpected", 1, 0);
      else begin
        me = mb_q.pop_front();
        chk("mb_x", bus.mb_x, me.x);
        chk("mb_y", bus.mb_y, me.y);
        chk("init_cycles", en_n, INIT_C);
        chk("run_cycles", run_n, PERIOD * PPM);
        chk("drain_cycles", dr_n, DRAIN_C);
        chk("report_stalls", st_n, me.s);
        fd_exp = (me.x == MB_COLS - 1 && me.y == MB_ROWS - 1);
      end
      en_n = 0; run_n = 0; dr_n = 0; st_n = 0;
    end
    if (pb && !bus.busy) begin
      if (fr_q.size() == 0) chk("frame_unexpected", 1, 0);
      else begin
        fe = fr_q.pop_front();
        if (fe.busy >= 0) chk("busy_cycles", busy_n, fe.busy);
        chk("stall_cycles", bus.stall_cycles, fe.stall);
        chk("frame_done_seen", fd_seen, fe.done);
      end
    end
    pb = bus.busy;
    if (!bus.busy) begin
      en_n = 0; run_n = 0; dr_n = 0; st_n = 0; busy_n = 0; fd_seen = 0;
    end
  end
  // mode: 0 plain, 1 frame_start pulses while busy, 2 abort in RUN of mb 1, 3 rst in DRAIN of mb 0
  task automatic run_frame(input int s0, input int s1, input int s2, input int s3, input int mode);
    int st[4];
    int k = 0, lo = 0, n = 0, runs = 0, sum;
    bit xf, ab, rs;
    st = '{s0, s1, s2, s3};
    sum = s0 + s1 + s2 + s3;
    if (mode < 2) begin
      for (int y = 0; y < MB_ROWS; y++)
        for (int x = 0; x < MB_COLS; x++) mb_q.push_back('{x, y, st[y * MB_COLS + x]});
      fr_q.push_back('{MB_COLS * MB_ROWS * MB_CYC + 1 + sum, PERF ? sum : 0, 1'b1});
    end else if (mode == 2) begin
      mb_q.push_back('{0, 0, s0});
      fr_q.push_back('{-1, PERF ? s0 : 0, 1'b0});
    end else fr_q.push_back('{-1, 0, 1'b0});
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    while (bus.busy) begin
      n++;
      if (n > 3000) begin
        chk("frame_timeout", n, 0);
        break;
      end
      bus.frame_start = 1'b0;
      bus.frame_abort = 1'b0;
      bus.mb_done_ready = 1'b1;
      if (bus.mb_done_valid && k < 4) begin
        bus.mb_done_ready = (lo >= st[k]);
        if (!bus.mb_done_ready) lo++;
      end
      if (mode == 1 && ((k == 1 && bus.en_init) || (k == 2 && bus.mb_done_valid))) bus.frame_start = 1'b1;
      if (mode == 2 && k == 1 && bus.run) begin
        runs++;
        if (runs == 10) bus.frame_abort = 1'b1;
      end
      if (mode == 3 && k == 0 && !bus.en_init && !bus.run && !bus.mb_done_valid) rst = 1'b1;
      xf = bus.mb_done_valid && bus.mb_done_ready && !bus.frame_abort && !rst;
      ab = bus.frame_abort;
      rs = rst;
      step();
      if (xf) begin
        k++;
        lo = 0;
      end
      if (ab) begin
        chk("abort_run", bus.run, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.frame_done, 0);
      end
      if (rs) begin
        chk("rst_mid_drain_outs", outs(), 0);
        rst = 1'b0;
      end
    end
    bus.frame_start = 1'b0;
    bus.frame_abort = 1'b0;
    bus.mb_done_ready = 1'b1;
    rst = 1'b0;
    step();
  endtask
  initial begin
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.frame_abort = 1'b0;
    bus.mb_done_ready = 1'b1;
    repeat (3) step();
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_outs", outs(), 0);
    chk("idle_busy", bus.busy, 0);
    bus.frame_start = 1'b1;
    bus.frame_abort = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.frame_abort = 1'b0;
    chk("start_abort_idle", bus.busy, 0);
    step();
    chk("start_abort_idle2", outs(), 0);
    run_frame(0, 0, 0, 0, 0);
    chk("keep_xy_after_done", {bus.mb_x, bus.mb_y}, 3);
    run_frame(0, 10, 0, 0, 0);
    run_frame(0, 0, 0, 0, 1);
    run_frame(2, 0, 0, 0, 2);
    run_frame(0, 0, 0, 0, 0);
    run_frame(0, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++)
      run_frame($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 0);
    repeat (5) step();
    chk("mb_queue_left", mb_q.size(), 0);
    chk("frame_queue_left", fr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
